// File: rtl/ft232h_burst_arbiter_pkg.sv
// Shared types and constants for the FT232H burst arbiter slice.
// Holds the arbiter state encoding, CMD encodings and default parameter values.
package ft232h_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RX    = 2'b01,
    TX    = 2'b10,
    DRAIN = 2'b11
  } state_t;

  typedef enum logic {
    DIR_RX = 1'b0,
    DIR_TX = 1'b1
  } dir_t;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_RD   = 2'b01;
  localparam logic [1:0] CMD_WR   = 2'b10;

  localparam int DEF_MAX_BURST    = 512;
  localparam int DEF_STALL_CYCLES = 4;
  localparam int DEF_TURN_CYCLES  = 2;
  localparam int DEF_CNT_W        = 32;

  // CMD is never 11; DRAIN and IDLE both park the interface.
  function automatic logic [1:0] cmd_of_state(input state_t st);
    case (st)
      RX:      return CMD_RD;
      TX:      return CMD_WR;
      default: return CMD_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ft232h_burst_arbiter_byte_counter.sv
// Wrapping byte counter with synchronous clear; a strobe coincident with the
// clear loads 1 so that byte is not lost.
module ft232h_byte_counter
  import ft232h_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic             clr,
  input  logic             strobe,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // Count register: clear wins over hold, but never over the incoming byte.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      count_r <= CNT_W'(0);
    end else if (clr) begin
      count_r <= CNT_W'(strobe);
    end else begin
      count_r <= count_r + CNT_W'(strobe);
    end
  end

  assign count = count_r;

endmodule

// File: rtl/ft232h_burst_arbiter.sv
// Round-robin half-duplex arbiter generating the FT232H sync-FIFO CMD.
// Optional macro FT232H_SIWU_FLUSH_EN adds the SIWUn short-packet flush output.
module ft232h_burst_arbiter
  import ft232h_pkg::*;
#(
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int STALL_CYCLES = DEF_STALL_CYCLES,
  parameter int TURN_CYCLES  = DEF_TURN_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic             rx_enable,
  input  logic             tx_enable,
  input  logic             cnt_clr,
  input  logic             RXFn,
  input  logic             TXEn,
  input  logic             rdempty,
  input  logic             wrfull,
  input  logic             wrreqin,
  input  logic             rdreqout,
  input  logic             OEn,
  input  logic             RDn,
  input  logic             WRn,
  output logic [1:0]       CMD,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] tx_count,
  output logic             busy
`ifdef FT232H_SIWU_FLUSH_EN
  ,
  output logic             SIWUn
`endif
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  localparam int TURN_W  = $clog2(TURN_CYCLES + 1);

  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);
  localparam logic [TURN_W-1:0]  TURN_MIN   = TURN_W'(TURN_CYCLES);

  state_t             state_r, state_nxt_s;
  dir_t               last_dir_r, last_dir_nxt_s;
  logic [BURST_W-1:0] burst_r, burst_nxt_s;
  logic [STALL_W-1:0] stall_r, stall_nxt_s;
  logic [TURN_W-1:0]  turn_r, turn_nxt_s;
  logic [1:0]         cmd_r;
  logic               busy_r;

  logic rx_req_s, tx_req_s;
  logic act_req_s, act_en_s, act_strobe_s;

  assign rx_req_s = rx_enable & ~RXFn & ~wrfull;
  assign tx_req_s = tx_enable & ~TXEn & ~rdempty;

  // Active-direction view so RX and TX share one set of grant rules.
  always_comb begin
    act_req_s    = 1'b0;
    act_en_s     = 1'b0;
    act_strobe_s = 1'b0;
    if (state_r == TX) begin
      act_req_s    = tx_req_s;
      act_en_s     = tx_enable;
      act_strobe_s = rdreqout;
    end else begin
      act_req_s    = rx_req_s;
      act_en_s     = rx_enable;
      act_strobe_s = wrreqin;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_nxt_s    = state_r;
    last_dir_nxt_s = last_dir_r;
    burst_nxt_s    = burst_r;
    stall_nxt_s    = stall_r;
    turn_nxt_s     = turn_r;

    case (state_r)
      IDLE: begin
        if (rx_req_s && (!tx_req_s || (last_dir_r == DIR_TX))) begin
          state_nxt_s    = RX;
          last_dir_nxt_s = DIR_RX;
          burst_nxt_s    = BURST_W'(0);
          stall_nxt_s    = STALL_W'(0);
        end else if (tx_req_s) begin
          state_nxt_s    = TX;
          last_dir_nxt_s = DIR_TX;
          burst_nxt_s    = BURST_W'(0);
          stall_nxt_s    = STALL_W'(0);
        end else begin
          state_nxt_s    = IDLE;
        end
      end

      RX, TX: begin
        if (act_strobe_s) begin
          burst_nxt_s = burst_r + BURST_W'(1);
        end else begin
          burst_nxt_s = burst_r;
        end

        if (act_req_s) begin
          stall_nxt_s = STALL_W'(0);
        end else begin
          stall_nxt_s = stall_r + STALL_W'(1);
        end

        // The strobe that completes the burst and the last stall cycle both end the grant now.
        if (!act_en_s ||
            (act_strobe_s && (burst_r == BURST_LAST)) ||
            (!act_req_s && (stall_r == STALL_LAST))) begin
          state_nxt_s = DRAIN;
          turn_nxt_s  = TURN_W'(0);
        end else begin
          state_nxt_s = state_r;
        end
      end

      DRAIN: begin
        if (turn_r < TURN_MIN) begin
          turn_nxt_s = turn_r + TURN_W'(1);
        end else begin
          turn_nxt_s = turn_r;
        end

        if ((turn_r >= TURN_MIN) && OEn && RDn && WRn) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end

      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; CMD and busy trail the state by one clk.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_r    <= IDLE;
      last_dir_r <= DIR_TX;
      burst_r    <= BURST_W'(0);
      stall_r    <= STALL_W'(0);
      turn_r     <= TURN_W'(0);
      cmd_r      <= CMD_IDLE;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      last_dir_r <= last_dir_nxt_s;
      burst_r    <= burst_nxt_s;
      stall_r    <= stall_nxt_s;
      turn_r     <= turn_nxt_s;
      cmd_r      <= cmd_of_state(state_r);
      busy_r     <= (state_r != IDLE);
    end
  end

  assign CMD  = cmd_r;
  assign busy = busy_r;

`ifdef FT232H_SIWU_FLUSH_EN
  logic siwun_r;

  // Push out a short packet when a TX grant closes with nothing left to send.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      siwun_r <= 1'b1;
    end else begin
      siwun_r <= ~((state_r == TX) && (state_nxt_s == DRAIN) && rdempty);
    end
  end

  assign SIWUn = siwun_r;
`endif

  ft232h_byte_counter #(
    .CNT_W (CNT_W)
  ) u_rx_cnt (
    .clk    (clk),
    .RSTn   (RSTn),
    .clr    (cnt_clr),
    .strobe (wrreqin),
    .count  (rx_count)
  );

  ft232h_byte_counter #(
    .CNT_W (CNT_W)
  ) u_tx_cnt (
    .clk    (clk),
    .RSTn   (RSTn),
    .clr    (cnt_clr),
    .strobe (rdreqout),
    .count  (tx_count)
  );

endmodule

// File: tb/tb_ft232h_burst_arbiter.sv
// Self-checking bench for ft232h_burst_arbiter: request table, scoreboarded
// byte counters and hand-written burst/stall/drain/reset sequences.
module tb_ft232h_burst_arbiter;

  localparam int MAX_BURST    = 512;
  localparam int STALL_CYCLES = 4;
  localparam int TURN_CYCLES  = 2;
  localparam int CNT_W        = 32;
  localparam int OEN_HOLD     = 6;

  logic             clk = 1'b0;
  logic             RSTn;
  logic             rx_enable, tx_enable, cnt_clr;
  logic             RXFn, TXEn, rdempty, wrfull;
  logic             wrreqin, rdreqout;
  logic             OEn, RDn, WRn;
  logic [1:0]       CMD;
  logic [CNT_W-1:0] rx_count, tx_count;
  logic             busy;
`ifdef FT232H_SIWU_FLUSH_EN
  logic             SIWUn;
`endif

  always #5 clk = ~clk;

  ft232h_burst_arbiter #(
    .MAX_BURST    (MAX_BURST),
    .STALL_CYCLES (STALL_CYCLES),
    .TURN_CYCLES  (TURN_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk       (clk),
    .RSTn      (RSTn),
    .rx_enable (rx_enable),
    .tx_enable (tx_enable),
    .cnt_clr   (cnt_clr),
    .RXFn      (RXFn),
    .TXEn      (TXEn),
    .rdempty   (rdempty),
    .wrfull    (wrfull),
    .wrreqin   (wrreqin),
    .rdreqout  (rdreqout),
    .OEn       (OEn),
    .RDn       (RDn),
    .WRn       (WRn),
    .CMD       (CMD),
    .rx_count  (rx_count),
    .tx_count  (tx_count),
    .busy      (busy)
`ifdef FT232H_SIWU_FLUSH_EN
    ,
    .SIWUn     (SIWUn)
`endif
  );

  typedef struct {
    logic       rx_en;
    logic       tx_en;
    logic       rxfn;
    logic       txen;
    logic       rde;
    logic       wrf;
    logic [1:0] cmd;
    logic       busy;
  } vec_t;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  vec_t        vecs [8];
  sb_t         sb_q [$];
  int          total  = 0;
  int          passed = 0;
  logic [31:0] rx_model, tx_model;
  int          siwu_lows;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic sb_drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.sel == 0) check(e.name, rx_count, e.exp);
      else            check(e.name, tx_count, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sb_drain();
  endtask

  task automatic drive_strobes(input logic w, input logic r, input logic clr);
    wrreqin  = w;
    rdreqout = r;
    cnt_clr  = clr;
    if (clr) begin
      rx_model = {31'd0, w};
      tx_model = {31'd0, r};
    end else begin
      rx_model = rx_model + {31'd0, w};
      tx_model = tx_model + {31'd0, r};
    end
    sb_q.push_back('{name: "sb_rx_count", sel: 0, exp: rx_model});
    sb_q.push_back('{name: "sb_tx_count", sel: 1, exp: tx_model});
  endtask

  task automatic set_req(input logic rx_en, input logic tx_en, input logic rxfn,
                         input logic txen, input logic rde, input logic wrf);
    rx_enable = rx_en;
    tx_enable = tx_en;
    RXFn      = rxfn;
    TXEn      = txen;
    rdempty   = rde;
    wrfull    = wrf;
  endtask

  task automatic do_reset();
    RSTn     = 1'b0;
    wrreqin  = 1'b0;
    rdreqout = 1'b0;
    cnt_clr  = 1'b0;
    OEn      = 1'b1;
    RDn      = 1'b1;
    WRn      = 1'b1;
    rx_model = 32'd0;
    tx_model = 32'd0;
    sb_q.delete();
    @(posedge clk);
    #1;
    RSTn = 1'b1;
  endtask

  initial begin
    logic [1:0] gval [4];
    int         glen [4];
    int         gap  [4];
    int         grants, zeros, ones, hold;
    logic [1:0] prev;

    RSTn = 1'b0;
    set_req(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    wrreqin = 1'b0; rdreqout = 1'b0; cnt_clr = 1'b0;
    OEn = 1'b1; RDn = 1'b1; WRn = 1'b1;
    #3;
    check("reset_cmd", 32'(CMD), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rx_count", rx_count, 32'd0);
    check("reset_tx_count", tx_count, 32'd0);

    // Request table: arbitration decision from IDLE right after reset.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    for (int i = 0; i < 8; i++) begin
      set_req(vecs[i].rx_en, vecs[i].tx_en, vecs[i].rxfn, vecs[i].txen, vecs[i].rde, vecs[i].wrf);
      do_reset();
      tick();
      check($sformatf("vec%0d_cmd_latency", i), 32'(CMD), 32'd0);
      tick();
      check($sformatf("vec%0d_cmd", i), 32'(CMD), 32'(vecs[i].cmd));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
    end

    // Full RX burst ends exactly at MAX_BURST strobes.
    set_req(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    do_reset();
    tick();
    tick();
    check("burst_start_cmd", 32'(CMD), 32'd1);
    for (int i = 0; i < MAX_BURST; i++) begin
      drive_strobes(1'b1, 1'b0, 1'b0);
      tick();
      if (i == MAX_BURST - 2) check("burst_mid_cmd", 32'(CMD), 32'd1);
    end
    drive_strobes(1'b0, 1'b0, 1'b0);
    tick();
    check("burst_end_cmd", 32'(CMD), 32'd0);
    check("burst_end_busy", 32'(busy), 32'd1);
    check("burst_rx_count", rx_count, 32'(MAX_BURST));

    // Alternating grants with both directions always requesting and strobing.
    set_req(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    wrreqin = 1'b1;
    rdreqout = 1'b1;
    for (int i = 0; i < 4; i++) begin
      gval[i] = 2'b00; glen[i] = 0; gap[i] = 0;
    end
    grants = 0; zeros = 0; ones = 0; hold = 0; prev = 2'b00;
    for (int cyc = 0; cyc < 3000 && grants < 4; cyc++) begin
      tick();
      if (hold > 0) begin
        hold--;
        if (hold == 0) OEn = 1'b1;
      end
      if (CMD != 2'b00) begin
        if (prev == 2'b00) begin
          gval[grants] = CMD;
          gap[grants]  = zeros;
          grants++;
          ones = 0;
        end
        ones++;
      end else begin
        if (prev != 2'b00) begin
          glen[grants-1] = ones;
          zeros = 0;
          if (grants == 1) begin
            OEn  = 1'b0;
            hold = OEN_HOLD;
          end
        end
        zeros++;
      end
      prev = CMD;
    end
    wrreqin = 1'b0;
    rdreqout = 1'b0;
    check("alt_grant_count", 32'(grants), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("alt_grant%0d_dir", i), 32'(gval[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
    for (int i = 0; i < 3; i++)
      check($sformatf("alt_grant%0d_len", i), 32'(glen[i]), 32'(MAX_BURST));
    check("alt_gap1_waits_oen", 32'(gap[1] > OEN_HOLD), 32'd1);
    for (int i = 2; i < 4; i++)
      check($sformatf("alt_gap%0d_min", i), 32'(gap[i] >= TURN_CYCLES), 32'd1);

    // TX stall exit: data runs out after 10 bytes.
    set_req(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    tick();
    tick();
    check("stall_start_cmd", 32'(CMD), 32'd2);
    for (int i = 0; i < 10; i++) begin
      drive_strobes(1'b0, 1'b1, 1'b0);
      tick();
    end
    drive_strobes(1'b0, 1'b0, 1'b0);
    rdempty = 1'b1;
    siwu_lows = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
`ifdef FT232H_SIWU_FLUSH_EN
      if (SIWUn == 1'b0) siwu_lows++;
`endif
      if (k == STALL_CYCLES)     check("stall_hold_cmd", 32'(CMD), 32'd2);
      if (k == STALL_CYCLES + 1) check("stall_exit_cmd", 32'(CMD), 32'd0);
    end
    check("stall_tx_count", tx_count, 32'd10);
`ifdef FT232H_SIWU_FLUSH_EN
    check("siwu_one_pulse", 32'(siwu_lows), 32'd1);
`endif

    // DRAIN holds while WRn is low, then returns to IDLE.
    set_req(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    tick();
    tick();
    check("drain_start_cmd", 32'(CMD), 32'd2);
    tx_enable = 1'b0;
    WRn = 1'b0;
    siwu_lows = 0;
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
`ifdef FT232H_SIWU_FLUSH_EN
      if (SIWUn == 1'b0) siwu_lows++;
`endif
      check("drain_hold_cmd", 32'(CMD), 32'd0);
      check("drain_hold_busy", 32'(busy), 32'd1);
    end
    WRn = 1'b1;
    tick();
    check("drain_release_busy_lag", 32'(busy), 32'd1);
    tick();
    check("drain_idle_busy", 32'(busy), 32'd0);
    check("drain_idle_cmd", 32'(CMD), 32'd0);
`ifdef FT232H_SIWU_FLUSH_EN
    check("siwu_no_pulse_pending", 32'(siwu_lows), 32'd0);
`endif

    // Counter wrap, coincident clear, strobes while IDLE.
    set_req(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    do_reset();
    tick();
    force dut.u_rx_cnt.count_r = 32'hFFFF_FFFF;
    #1;
    release dut.u_rx_cnt.count_r;
    #1;
    check("wrap_preset", rx_count, 32'hFFFF_FFFF);
    rx_model = 32'hFFFF_FFFF;
    drive_strobes(1'b1, 1'b1, 1'b0);
    tick();
    check("wrap_zero", rx_count, 32'd0);
    drive_strobes(1'b0, 1'b1, 1'b0);
    tick();
    drive_strobes(1'b1, 1'b0, 1'b1);
    tick();
    check("clr_coincident_rx", rx_count, 32'd1);
    check("clr_tx", tx_count, 32'd0);
    drive_strobes(1'b0, 1'b0, 1'b1);
    tick();
    drive_strobes(1'b1, 1'b0, 1'b0);
    tick();
    drive_strobes(1'b0, 1'b0, 1'b0);
    tick();

    // Asynchronous reset in the middle of a TX burst.
    set_req(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_strobes(1'b0, 1'b1, 1'b0);
      tick();
    end
    check("midreset_pre_cmd", 32'(CMD), 32'd2);
    #2;
    RSTn = 1'b0;
    #1;
    check("midreset_cmd", 32'(CMD), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_tx_count", tx_count, 32'd0);
    check("midreset_rx_count", rx_count, 32'd0);
    rdreqout = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
